// File: rtl/alu_result_fifo.sv
// Result FIFO between the combinational ALU and its consumer: stores {cout, overflow, zero, result}.
// Optional sticky overflow/carry status is compiled in when ALU_STICKY_FLAGS_EN is defined.
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_cout,
    output logic [AW:0]      count,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic             sticky_clear,
    output logic             sticky_ovf,
    output logic             sticky_cout,
`endif
    output logic [7:0]       drop_count
);

    localparam int EW = WIDTH + 3;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          full, empty, push, pop;
    logic [EW-1:0] head;

    // Handshake: a transfer happens on a port in any cycle where valid and ready are both high;
    // ready never depends on valid on the same port, and in_ready ignores out_ready (no full-bypass).
    always_comb begin
        full     = (count_q == DEPTH_CNT);
        empty    = (count_q == '0);
        push     = in_valid && !full;
        pop      = !empty && out_ready;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        drop_d   = drop_q;
        if (in_valid && full && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {in_cout, in_overflow, in_zero, in_result};
        end
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        in_ready     = !full;
        out_valid    = !empty;
        out_result   = empty ? '0   : head[WIDTH-1:0];
        out_zero     = empty ? 1'b0 : head[WIDTH];
        out_overflow = empty ? 1'b0 : head[WIDTH+1];
        out_cout     = empty ? 1'b0 : head[WIDTH+2];
        count        = count_q;
        drop_count   = drop_q;
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic sticky_ovf_q, sticky_ovf_d;
    logic sticky_cout_q, sticky_cout_d;

    // A set in the same cycle as a clear wins; dropped results never reach here since push is gated.
    always_comb begin
        sticky_ovf_d  = sticky_clear ? 1'b0 : sticky_ovf_q;
        sticky_cout_d = sticky_clear ? 1'b0 : sticky_cout_q;
        if (push && in_overflow) sticky_ovf_d  = 1'b1;
        if (push && in_cout)     sticky_cout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_ovf_q  <= 1'b0;
            sticky_cout_q <= 1'b0;
        end else begin
            sticky_ovf_q  <= sticky_ovf_d;
            sticky_cout_q <= sticky_cout_d;
        end
    end

    assign sticky_ovf  = sticky_ovf_q;
    assign sticky_cout = sticky_cout_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus hand-written multi-cycle sequences.
// Covers the ALU_STICKY_FLAGS_EN status bits when that macro is defined.
module tb_alu_result_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_zero, in_overflow, in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero, out_overflow, out_cout;
    logic [AW:0]      count;
    logic [7:0]       drop_count;
`ifdef ALU_STICKY_FLAGS_EN
    logic             sticky_clear;
    logic             sticky_ovf, sticky_cout;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_cout      (in_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_cout     (out_cout),
        .count        (count),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_clear (sticky_clear),
        .sticky_ovf   (sticky_ovf),
        .sticky_cout  (sticky_cout),
`endif
        .drop_count   (drop_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] data;
        logic [2:0]       fl;     // {cout, overflow, zero}
        logic             ordy;
        logic             e_ov;
        logic             e_ir;
        logic [AW:0]      e_cnt;
        logic [WIDTH-1:0] e_res;
        logic [2:0]       e_fl;
        logic [7:0]       e_drop;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t mk(logic iv, logic [WIDTH-1:0] data, logic [2:0] fl, logic ordy,
                                logic e_ov, logic e_ir, logic [AW:0] e_cnt,
                                logic [WIDTH-1:0] e_res, logic [2:0] e_fl, logic [7:0] e_drop);
        vec_t v;
        v.iv = iv; v.data = data; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt;
        v.e_res = e_res; v.e_fl = e_fl; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] data, input logic [2:0] fl,
                         input logic ordy);
        @(negedge clk);
        in_valid    = iv;
        in_result   = data;
        in_cout     = fl[2];
        in_overflow = fl[1];
        in_zero     = fl[0];
        out_ready   = ordy;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clear = 1'b0;
`endif
        // Push attempts during reset must be discarded.
        in_valid = 1'b1; in_result = 32'hDEAD_BEEF;
        in_zero = 1'b0; in_overflow = 1'b1; in_cout = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;

        // Expected values are those visible during the cycle the inputs are applied.
        vt[0]  = mk(0, 0,            3'b000, 0,  0, 1, 0, 0,            3'b000, 0);
        vt[1]  = mk(1, 32'h0,        3'b001, 0,  0, 1, 0, 0,            3'b000, 0);
        vt[2]  = mk(1, 32'hFFFF_FFFF,3'b100, 0,  1, 1, 1, 0,            3'b001, 0);
        vt[3]  = mk(0, 0,            3'b000, 0,  1, 1, 2, 0,            3'b001, 0);
        vt[4]  = mk(0, 0,            3'b000, 1,  1, 1, 2, 0,            3'b001, 0);
        vt[5]  = mk(0, 0,            3'b000, 1,  1, 1, 1, 32'hFFFF_FFFF,3'b100, 0);
        vt[6]  = mk(0, 0,            3'b000, 0,  0, 1, 0, 0,            3'b000, 0);
        vt[7]  = mk(1, 1,            3'b000, 0,  0, 1, 0, 0,            3'b000, 0);
        vt[8]  = mk(1, 2,            3'b000, 0,  1, 1, 1, 1,            3'b000, 0);
        vt[9]  = mk(1, 3,            3'b000, 0,  1, 1, 2, 1,            3'b000, 0);
        vt[10] = mk(1, 4,            3'b000, 0,  1, 1, 3, 1,            3'b000, 0);
        vt[11] = mk(1, 5,            3'b000, 0,  1, 0, 4, 1,            3'b000, 0);
        vt[12] = mk(0, 0,            3'b000, 1,  1, 0, 4, 1,            3'b000, 1);
        vt[13] = mk(0, 0,            3'b000, 1,  1, 1, 3, 2,            3'b000, 1);
        vt[14] = mk(0, 0,            3'b000, 1,  1, 1, 2, 3,            3'b000, 1);
        vt[15] = mk(0, 0,            3'b000, 1,  1, 1, 1, 4,            3'b000, 1);
        vt[16] = mk(0, 0,            3'b000, 0,  0, 1, 0, 0,            3'b000, 1);
        vt[17] = mk(1, 32'hA1,       3'b010, 0,  0, 1, 0, 0,            3'b000, 1);
        vt[18] = mk(1, 32'hA2,       3'b000, 0,  1, 1, 1, 32'hA1,       3'b010, 1);
        vt[19] = mk(1, 32'hA3,       3'b000, 0,  1, 1, 2, 32'hA1,       3'b010, 1);
        vt[20] = mk(1, 32'hA4,       3'b000, 0,  1, 1, 3, 32'hA1,       3'b010, 1);
        vt[21] = mk(1, 32'hB5,       3'b000, 1,  1, 0, 4, 32'hA1,       3'b010, 1);
        vt[22] = mk(1, 32'hB6,       3'b101, 0,  1, 1, 3, 32'hA2,       3'b000, 2);
        vt[23] = mk(0, 0,            3'b000, 0,  1, 0, 4, 32'hA2,       3'b000, 2);
        vt[24] = mk(0, 0,            3'b000, 1,  1, 0, 4, 32'hA2,       3'b000, 2);
        vt[25] = mk(0, 0,            3'b000, 1,  1, 1, 3, 32'hA3,       3'b000, 2);
        vt[26] = mk(0, 0,            3'b000, 1,  1, 1, 2, 32'hA4,       3'b000, 2);
        vt[27] = mk(0, 0,            3'b000, 1,  1, 1, 1, 32'hB6,       3'b101, 2);
        vt[28] = mk(0, 0,            3'b000, 0,  0, 1, 0, 0,            3'b000, 2);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].iv, vt[i].data, vt[i].fl, vt[i].ordy);
            chk($sformatf("v%0d out_valid", i),  64'(out_valid),  64'(vt[i].e_ov));
            chk($sformatf("v%0d in_ready", i),   64'(in_ready),   64'(vt[i].e_ir));
            chk($sformatf("v%0d count", i),      64'(count),      64'(vt[i].e_cnt));
            chk($sformatf("v%0d out_result", i), 64'(out_result), 64'(vt[i].e_res));
            chk($sformatf("v%0d flags", i),      64'({out_cout, out_overflow, out_zero}), 64'(vt[i].e_fl));
            chk($sformatf("v%0d drop_count", i), 64'(drop_count), 64'(vt[i].e_drop));
        end

        // Steady push+pop at count=2: pointers wrap, order preserved.
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h100 + i, 3'b000, 0);
            exp_q.push_back(32'h100 + i);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h200 + k, 3'b000, 1);
            chk($sformatf("wrap%0d count", k), 64'(count), 64'd2);
            chk($sformatf("wrap%0d head", k), 64'(out_result), 64'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(32'h200 + k);
        end
        while (exp_q.size() > 0) begin
            drive(0, 0, 3'b000, 1);
            chk("drain valid", 64'(out_valid), 64'd1);
            chk("drain head", 64'(out_result), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        drive(0, 0, 3'b000, 0);
        chk("drained count", 64'(count), 64'd0);
        chk("drained out_result", 64'(out_result), 64'd0);

        // drop_count saturation: fill, then offer 260 words while full.
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h300 + i, 3'b000, 0);
        for (int i = 0; i < 260; i++) drive(1, 32'h400 + i, 3'b000, 0);
        drive(0, 0, 3'b000, 0);
        chk("sat drop_count", 64'(drop_count), 64'hFF);
        chk("sat count", 64'(count), 64'd4);
        chk("sat head", 64'(out_result), 64'h300);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 3'b000, 1);
        drive(0, 0, 3'b000, 0);
        chk("sat drained", 64'(count), 64'd0);

`ifdef ALU_STICKY_FLAGS_EN
        drive(0, 0, 3'b000, 1);
        sticky_clear = 1'b1;
        drive(0, 0, 3'b000, 1);
        sticky_clear = 1'b0;
        chk("sticky cleared ovf", 64'(sticky_ovf), 64'd0);
        chk("sticky cleared cout", 64'(sticky_cout), 64'd0);
        drive(1, 32'h11, 3'b010, 1);
        drive(1, 32'h12, 3'b010, 1);
        sticky_clear = 1'b1;
        chk("sticky ovf set", 64'(sticky_ovf), 64'd1);
        drive(0, 0, 3'b000, 1);
        chk("sticky set wins", 64'(sticky_ovf), 64'd1);
        drive(0, 0, 3'b000, 1);
        sticky_clear = 1'b0;
        chk("sticky clear alone", 64'(sticky_ovf), 64'd0);
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h500 + i, 3'b000, 0);
        drive(1, 32'h5FF, 3'b100, 0);
        drive(0, 0, 3'b000, 0);
        chk("dropped no sticky", 64'(sticky_cout), 64'd0);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 3'b000, 1);
`endif

        drive(0, 0, 3'b000, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
